// File: rtl/error_countdown_timer_pkg.sv
// ----------------------------------------------------------------------------
// error_countdown_timer_pkg
// Shared definitions for the error-state countdown timer:
//   - central FSM state codes (as seen on current_state)
//   - internal timer state encoding
//   - default timing / countdown-length parameters
// ----------------------------------------------------------------------------
package error_countdown_timer_pkg;

    localparam int STATE_W = 4;
    localparam int TIME_W  = 4;

    // Central FSM state codes. Only STATE_IDLE and STATE_CALC_ERROR matter to
    // the timer; the rest are listed so every consumer shares one encoding.
    typedef enum logic [STATE_W-1:0] {
        STATE_IDLE        = 4'd0,
        STATE_INPUT_A     = 4'd1,
        STATE_INPUT_B     = 4'd2,
        STATE_SELECT_OP   = 4'd3,
        STATE_CALC        = 4'd4,
        STATE_SHOW_RESULT = 4'd5,
        STATE_CALC_ERROR  = 4'd12,
        STATE_CONFIG_MODE = 4'd13
    } fsm_state_e;

    // Internal timer states.
    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } timer_state_e;

    localparam int DEF_TICK_CYCLES = 100_000_000;
    localparam int DEF_CFG_MIN     = 5;
    localparam int DEF_CFG_MAX     = 15;
    localparam int DEF_CFG_DEFAULT = 10;

endpackage

// File: rtl/error_countdown_timer_if.sv
// ----------------------------------------------------------------------------
// error_countdown_timer_if
// Bundles the timer's control inputs and status outputs.
//   current_state [4] : central FSM state code          (master -> slave)
//   cfg_we        [1] : one-cycle countdown-length write (master -> slave)
//   cfg_value     [4] : requested seconds for cfg_we     (master -> slave)
//   time_left     [4] : seconds remaining                (slave -> master)
//   timeout       [1] : one-cycle pulse at zero          (slave -> master)
//   busy          [1] : high while counting              (slave -> master)
//   cfg_seconds   [4] : current countdown length         (slave -> master)
// master = central FSM side, slave = the timer.
// ----------------------------------------------------------------------------
interface error_countdown_timer_if;
    import error_countdown_timer_pkg::*;

    logic [STATE_W-1:0] current_state;
    logic               cfg_we;
    logic [TIME_W-1:0]  cfg_value;
    logic [TIME_W-1:0]  time_left;
    logic               timeout;
    logic               busy;
    logic [TIME_W-1:0]  cfg_seconds;

    modport master (
        output current_state, cfg_we, cfg_value,
        input  time_left, timeout, busy, cfg_seconds
    );

    modport slave (
        input  current_state, cfg_we, cfg_value,
        output time_left, timeout, busy, cfg_seconds
    );

endinterface

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle tick every TICK_CYCLES enabled
// clocks. Reusable wherever a 1 Hz (or other) strobe is needed.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear of the count (wins over en)
//   en    : count enable
//   tick  : high during the last cycle of each TICK_CYCLES window (en=1)
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // tick is combinational so the consumer can act on the same edge that
    // wraps the counter.
    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/error_countdown_timer.sv
// ----------------------------------------------------------------------------
// error_countdown_timer
// Countdown shown while the central FSM sits in STATE_CALC_ERROR. Each fresh
// entry loads cfg_seconds and decrements once per TICK_CYCLES clocks; at zero
// a single timeout pulse tells the FSM to leave the error state. The length
// register is writable only while idle and is clamped to CFG_MIN..CFG_MAX.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : error_countdown_timer_if.slave (current_state, cfg_we, cfg_value
//           in; time_left, timeout, busy, cfg_seconds out, all registered)
// ----------------------------------------------------------------------------
module error_countdown_timer
    import error_countdown_timer_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int CFG_MIN     = DEF_CFG_MIN,
    parameter int CFG_MAX     = DEF_CFG_MAX,
    parameter int CFG_DEFAULT = DEF_CFG_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    error_countdown_timer_if.slave  bus
);

    timer_state_e        state_q, state_d;
    logic [STATE_W-1:0]  prev_state_q;
    logic [TIME_W-1:0]   time_left_q, time_left_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic [TIME_W-1:0]   cfg_q, cfg_d;

    logic in_error;
    logic entry;
    logic tick;
    logic presc_clr;
    logic presc_en;

    function automatic logic [TIME_W-1:0] clamp_cfg(input logic [TIME_W-1:0] v);
        logic [TIME_W-1:0] r;
        r = v;
        if (int'(v) < CFG_MIN) begin
            r = TIME_W'(CFG_MIN);
        end else if (int'(v) > CFG_MAX) begin
            r = TIME_W'(CFG_MAX);
        end
        return r;
    endfunction

    assign in_error = (bus.current_state == STATE_CALC_ERROR);
    assign entry    = in_error && (prev_state_q != STATE_CALC_ERROR);

    // The prescaler only runs while counting; any abort or non-counting state
    // holds it at zero so a reload always starts a full first second.
    assign presc_en  = (state_q == T_COUNT);
    assign presc_clr = (state_q != T_COUNT) || !in_error;

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        timeout_d   = 1'b0;
        cfg_d       = cfg_q;

        case (state_q)
            T_IDLE: begin
                time_left_d = '0;
                // An entry in the same cycle as a write loads the old length
                // and drops the write.
                if (entry) begin
                    time_left_d = cfg_q;
                    state_d     = T_COUNT;
                end else if (bus.cfg_we) begin
                    cfg_d = clamp_cfg(bus.cfg_value);
                end
            end

            T_COUNT: begin
                // Leaving the error state wins over a coincident tick.
                if (!in_error) begin
                    time_left_d = '0;
                    state_d     = T_IDLE;
                end else if (tick) begin
                    if (time_left_q > TIME_W'(1)) begin
                        time_left_d = time_left_q - TIME_W'(1);
                    end else begin
                        time_left_d = '0;
                        timeout_d   = 1'b1;
                        state_d     = T_EXPIRED;
                    end
                end
            end

            T_EXPIRED: begin
                time_left_d = '0;
                if (!in_error) begin
                    state_d = T_IDLE;
                end
            end

            default: begin
                time_left_d = '0;
                state_d     = T_IDLE;
            end
        endcase

        busy_d = (state_d == T_COUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_q <= STATE_IDLE;
            time_left_q  <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            cfg_q        <= TIME_W'(CFG_DEFAULT);
        end else begin
            prev_state_q <= bus.current_state;
            time_left_q  <= time_left_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            cfg_q        <= cfg_d;
        end
    end

    assign bus.time_left   = time_left_q;
    assign bus.timeout     = timeout_q;
    assign bus.busy        = busy_q;
    assign bus.cfg_seconds = cfg_q;

endmodule

// File: tb/tb_error_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_error_countdown_timer
// Directed bench for error_countdown_timer with TICK_CYCLES=4.
// ----------------------------------------------------------------------------
module tb_error_countdown_timer;

    logic clk;
    logic rst_n;

    error_countdown_timer_if bus_if ();

    error_countdown_timer #(
        .TICK_CYCLES (4),
        .CFG_MIN     (5),
        .CFG_MAX     (15),
        .CFG_DEFAULT (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cs;
        logic       we;
        logic [3:0] val;
        logic [3:0] tl;
        logic       to;
        logic       busy;
        logic [3:0] cfg;
    } vec_t;

    vec_t vecs [11];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [3:0] tl, input logic to,
                               input logic busy, input logic [3:0] cfg);
        chk({tag, ".time_left"},   bus_if.time_left,       tl);
        chk({tag, ".timeout"},     {3'b0, bus_if.timeout}, {3'b0, to});
        chk({tag, ".busy"},        {3'b0, bus_if.busy},    {3'b0, busy});
        chk({tag, ".cfg_seconds"}, bus_if.cfg_seconds,     cfg);
    endtask

    // Drive one cycle of inputs, clock it, and check the registered outputs.
    task automatic step(input string tag, input logic [3:0] cs, input logic we,
                        input logic [3:0] val, input logic [3:0] tl, input logic to,
                        input logic busy, input logic [3:0] cfg);
        bus_if.current_state = cs;
        bus_if.cfg_we        = we;
        bus_if.cfg_value     = val;
        @(posedge clk);
        #1;
        chk_outputs(tag, tl, to, busy, cfg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        //            cs     we    val    tl     to    busy  cfg
        vecs[0]  = '{4'd0,  1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 4'd10};
        vecs[1]  = '{4'd0,  1'b1, 4'd2,  4'd0, 1'b0, 1'b0, 4'd5};  // clamp low
        vecs[2]  = '{4'd13, 1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 4'd15}; // max kept
        vecs[3]  = '{4'd13, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 4'd5};  // zero -> min
        vecs[4]  = '{4'd13, 1'b1, 4'd7,  4'd0, 1'b0, 1'b0, 4'd7};
        vecs[5]  = '{4'd13, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 4'd7};
        vecs[6]  = '{4'd12, 1'b0, 4'd0,  4'd7, 1'b0, 1'b1, 4'd7};  // entry edge
        vecs[7]  = '{4'd12, 1'b1, 4'd3,  4'd7, 1'b0, 1'b1, 4'd7};  // write while busy
        vecs[8]  = '{4'd12, 1'b0, 4'd0,  4'd7, 1'b0, 1'b1, 4'd7};
        vecs[9]  = '{4'd12, 1'b0, 4'd0,  4'd7, 1'b0, 1'b1, 4'd7};
        vecs[10] = '{4'd12, 1'b0, 4'd0,  4'd6, 1'b0, 1'b1, 4'd7};  // first decrement

        // Reset state
        rst_n                = 1'b0;
        bus_if.current_state = 4'd0;
        bus_if.cfg_we        = 1'b0;
        bus_if.cfg_value     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset", 4'd0, 1'b0, 1'b0, 4'd10);
        rst_n = 1'b1;

        // Config, clamp and start of a 7-second countdown
        for (int i = 0; i < 11; i++) begin
            step($sformatf("vec%0d", i), vecs[i].cs, vecs[i].we, vecs[i].val,
                 vecs[i].tl, vecs[i].to, vecs[i].busy, vecs[i].cfg);
        end

        // Rest of the countdown: k edges after the load edge
        for (int k = 5; k <= 28; k++) begin
            step($sformatf("count_k%0d", k), 4'd12, 1'b0, 4'd0,
                 4'(7 - k / 4), (k == 28), (k < 28), 4'd7);
        end

        // Expired: hold zero, no further pulses, writes ignored
        step("expired_write", 4'd12, 1'b1, 4'd9, 4'd0, 1'b0, 1'b0, 4'd7);
        for (int j = 0; j < 6; j++) begin
            step($sformatf("expired_hold%0d", j), 4'd12, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7);
        end

        // Abort after 9 cycles, then re-entry on the next cycle
        step("leave_expired", 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7);
        step("cfg5",          4'd0, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 4'd5);
        step("abort_load",    4'd12, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 4'd5);
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("abort_k%0d", k), 4'd12, 1'b0, 4'd0, 4'(5 - k / 4), 1'b0, 1'b1, 4'd5);
        end
        step("abort",   4'd0,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5);
        step("reentry", 4'd12, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 4'd5);
        for (int k = 1; k <= 3; k++) begin
            step($sformatf("reentry_k%0d", k), 4'd12, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 4'd5);
        end
        // Abort on the very edge a tick would decrement: abort wins
        step("abort_on_tick", 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5);
        step("idle_after",    4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5);

        // Same-cycle write and entry: write dropped, old length loaded
        step("cfg10",       4'd0,  1'b1, 4'd10, 4'd0,  1'b0, 1'b0, 4'd10);
        step("same_cycle",  4'd12, 1'b1, 4'd6,  4'd10, 1'b0, 1'b1, 4'd10);
        step("same_after",  4'd12, 1'b0, 4'd0,  4'd10, 1'b0, 1'b1, 4'd10);
        step("same_leave",  4'd0,  1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd10);

        // Asynchronous reset mid-count at time_left=3
        step("rst_cfg5", 4'd0,  1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 4'd5);
        step("rst_load", 4'd12, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 4'd5);
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("rst_k%0d", k), 4'd12, 1'b0, 4'd0, 4'(5 - k / 4), 1'b0, 1'b1, 4'd5);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs("async_reset", 4'd0, 1'b0, 1'b0, 4'd10);
        for (int j = 0; j < 6; j++) begin
            step($sformatf("in_reset%0d", j), 4'd12, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd10);
        end
        rst_n = 1'b1;
        step("post_reset", 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/error_countdown_timer.md
# error_countdown_timer

Generates the error-state countdown consumed by the 7-segment driver. On each entry into STATE_CALC_ERROR it loads a configurable number of seconds and decrements once per second. At zero it issues a one-cycle timeout pulse that the central FSM uses to leave the error state. The countdown length is written from config mode and held in a validated register.

## Interface
Parameters:
- TICK_CYCLES, 100_000_000, clock cycles per second (≥2; the bench uses 4)
- CFG_MIN, 5, minimum countdown seconds (≥1)
- CFG_MAX, 15, maximum countdown seconds (≤15)
- CFG_DEFAULT, 10, countdown seconds after reset (CFG_MIN..CFG_MAX)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- current_state  in  4  central FSM state code
- cfg_we  in  1  one-cycle write strobe for the countdown length
- cfg_value  in  4  requested seconds, sampled when cfg_we=1
- time_left  out  4  seconds remaining, registered
- timeout  out  1  one-cycle pulse when the countdown reaches 0
- busy  out  1  high while counting
- cfg_seconds  out  4  current countdown-length register

## Operation
- Internal FSM has three states:
  - T_IDLE: not counting.
  - T_COUNT: counting down.
  - T_EXPIRED: reached 0, waiting for the FSM to leave the error state.
- prev_state register captures current_state every cycle. entry = (current_state==STATE_CALC_ERROR) && (prev_state!=STATE_CALC_ERROR).
- T_IDLE:
  - time_left=0, busy=0.
  - On entry: time_left<=cfg_seconds, prescaler<=0, go to T_COUNT.
- T_COUNT:
  - busy=1. Prescaler counts 0..TICK_CYCLES-1, then wraps; tick = (prescaler==TICK_CYCLES-1).
  - On tick with time_left>1: time_left<=time_left-1.
  - On tick with time_left==1: time_left<=0, timeout<=1 for exactly one cycle, go to T_EXPIRED.
- T_EXPIRED:
  - time_left holds 0, busy=0, no further timeout pulses.
- Abort: if current_state!=STATE_CALC_ERROR while in T_COUNT or T_EXPIRED, go to T_IDLE, time_left<=0, prescaler<=0, no timeout. Abort takes priority over tick in the same cycle.
- Restart: the error state can be left and re-entered on consecutive cycles. Each fresh entry reloads the full count from T_IDLE.
- Config write:
  - Accepted only in T_IDLE with entry=0. Otherwise ignored; writes are not queued.
  - Clamped: cfg_value<CFG_MIN stores CFG_MIN; cfg_value>CFG_MAX stores CFG_MAX.
  - If a write and an entry occur in the same cycle, the write is dropped and the count loads the old cfg_seconds.
- Arithmetic: 4-bit unsigned time_left never underflows (minimum load is CFG_MIN≥1). Prescaler width is $clog2(TICK_CYCLES).

## Timing
- Reset values: time_left=0, timeout=0, busy=0, cfg_seconds=CFG_DEFAULT, prev_state=STATE_IDLE, FSM=T_IDLE, prescaler=0.
- All outputs are registered and there is no combinational input-to-output path.
- Load latency: if current_state becomes 12 before edge E, then at edge E time_left=cfg_seconds and busy=1.
- Decrement timing: the first decrement lands at edge E+TICK_CYCLES, and each later one every TICK_CYCLES cycles.
- Expiry: timeout is high for the single cycle following edge E+cfg_seconds×TICK_CYCLES; busy falls on the same edge.
- Config latency: cfg_seconds updates on the edge after cfg_we.
- Reset mid-count clears all state immediately (asynchronous). Resynchronisation is left to the FSM.

## Structure
- Shared package holds:
  - FSM state codes: STATE_IDLE=0, STATE_CONFIG_MODE=13, STATE_CALC_ERROR=12, and the others.
  - Timer-state encoding T_IDLE/T_COUNT/T_EXPIRED.
  - The CFG_* defaults.
- Sub-module tick_prescaler(clk, rst_n, clr, en, tick) with parameter TICK_CYCLES; reusable for other 1 Hz needs.
- Top level holds the FSM, the time_left counter, the config register and edge detection.

## Test plan
All scenarios use TICK_CYCLES=4.
- Reset, then idle: time_left=0, busy=0, cfg_seconds=10, timeout never asserts.
- cfg_we with cfg_value=7 in idle, then enter state 12: time_left=7 at the next edge, then 6,5,…,1,0 every 4 cycles. timeout is a single pulse 28 cycles after load, then time_left stays 0.
- Clamp: cfg_value=2 stores 5, and cfg_value=15 stores 15. A write while busy=1 leaves cfg_seconds unchanged.
- Abort: with cfg_seconds=5, leave state 12 after 9 cycles: time_left=0, busy=0, no timeout. Re-enter on the next cycle: reloads 5.
- Same-cycle write and entry: cfg_seconds=10 with cfg_value=6 written at the entry edge: loads 10, and cfg_seconds stays 10.
- Assert rst_n low mid-count at time_left=3: outputs return to reset values at once, with no timeout pulse.
